// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: address FSM states and the
// {instruction, pc} record held in the instruction buffer.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef enum logic [0:0] {
        FETCH_IDLE,
        FETCH_REQ
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and a flush that empties it.
// Push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage is not reset; contents are only observed while count is nonzero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    assert property (@(posedge clk) disable iff (!rst_n) push |-> (!full || do_pop || flush))
        else $error("sync_fifo overflow");
    assert property (@(posedge clk) disable iff (!rst_n) pop |-> (!empty || flush))
        else $error("sync_fifo underflow");

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues PC fetch addresses on the instruction bus and
// returns PC-tagged instructions to the decoder; a flush drops all older fetches.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic              flush_i,
    output logic              instr_req_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [DATA_W-1:0] instr_rdata_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned EntW = $bits(fetch_entry_t);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              stale_q, stale_d;
    logic [CntW-1:0]   discard_q, discard_d;
    logic [CntW:0]     discard_sum;
    logic [CntW-1:0]   tag_count, buf_count;
    logic [ADDR_W-1:0] tag_pc;
    logic              req_live, tag_push, rsp_live, buf_pop, credit_ok;
    fetch_entry_t      buf_wdata, buf_rdata;

    // A request raised before a flush stays on the bus; it is live only if not stale.
    assign req_live  = (state_q == FETCH_REQ) && !stale_q;
    assign tag_push  = req_live && instr_gnt_i;
    assign rsp_live  = instr_rvalid_i && (discard_q == '0);
    assign buf_pop   = instr_valid_o && instr_ready_i;
    assign credit_ok = ((CntW+1)'(tag_count) + (CntW+1)'(buf_count)) < (CntW+1)'(DEPTH);

    assign pc_ready_o = rst_n && !flush_i && (state_q == FETCH_IDLE) &&
                        (discard_q == '0) && credit_ok;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        unique case (state_q)
            FETCH_IDLE: begin
                if (pc_valid_i && pc_ready_o) begin
                    state_d = FETCH_REQ;
                    pc_d    = pc_i;
                    stale_d = 1'b0;
                end
            end
            FETCH_REQ: begin
                if (instr_gnt_i) begin
                    state_d = FETCH_IDLE;
                    stale_d = 1'b0;
                end else if (flush_i) begin
                    stale_d = 1'b1;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // On flush every in-flight response (plus a live pending request) becomes a discard.
    always_comb begin
        discard_sum = (CntW+1)'(discard_q) + (CntW+1)'(tag_count) + (CntW+1)'(req_live) -
                      (CntW+1)'(instr_rvalid_i);
        discard_d   = discard_q;
        if (flush_i) begin
            discard_d = discard_sum[CntW-1:0];
        end else if (instr_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= '0;
            stale_q   <= 1'b0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stale_q   <= stale_d;
            discard_q <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_push),
        .wdata (pc_q),
        .pop   (rsp_live),
        .flush (flush_i),
        .rdata (tag_pc),
        .count (tag_count)
    );

    assign buf_wdata.instr = instr_rdata_i;
    assign buf_wdata.pc    = tag_pc;

    sync_fifo #(
        .WIDTH (EntW),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_live),
        .wdata (buf_wdata),
        .pop   (buf_pop),
        .flush (flush_i),
        .rdata (buf_rdata),
        .count (buf_count)
    );

    assign instr_req_o   = (state_q == FETCH_REQ);
    assign instr_addr_o  = {pc_q[ADDR_W-1:2], 2'b00};
    assign instr_valid_o = (buf_count != '0);
    assign instr_o       = instr_valid_o ? buf_rdata.instr : '0;
    assign instr_pc_o    = instr_valid_o ? buf_rdata.pc : '0;

    assert property (@(posedge clk) disable iff (!rst_n) flush_i |-> discard_sum <= (CntW+1)'(DEPTH))
        else $error("discard counter overflow");
    assert property (@(posedge clk) disable iff (!rst_n) rsp_live |-> tag_count != '0)
        else $error("response without outstanding request");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];    // PCs accepted since the last flush, in delivery order
    logic [31:0] bus_addr[$]; // granted addresses awaiting a response
    int          bus_cyc[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_i           (pc_i),
        .pc_valid_i     (pc_valid_i),
        .pc_ready_o     (pc_ready_o),
        .flush_i        (flush_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .instr_ready_i  (instr_ready_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, a[31:16]};
    endfunction

    // Single fetch: handshake N, grant N+1, response N+2, instruction at N+3.
    task automatic run_vec(input vec_t v);
        pc_valid_i = 1'b1;
        pc_i       = v.pc;
        #1 check("vec_pc_ready", pc_ready_o, 1);
        tick();
        pc_valid_i  = 1'b0;
        instr_gnt_i = 1'b1;
        #1 check("vec_req", instr_req_o, 1);
        check("vec_addr", instr_addr_o, v.exp_addr);
        tick();
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = v.rdata;
        #1 check("vec_valid_early", instr_valid_o, 0);
        tick();
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        #1 check("vec_valid", instr_valid_o, 1);
        check("vec_instr", instr_o, v.rdata);
        check("vec_instr_pc", instr_pc_o, v.exp_pc);
        tick();
        #1 check("vec_consumed", instr_valid_o, 0);
    endtask

    // Handshake one PC and grant it immediately; no response.
    task automatic issue(input logic [31:0] a);
        int n;
        n          = 0;
        pc_valid_i = 1'b1;
        pc_i       = a;
        #1;
        while (!pc_ready_o && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("issue_accept", pc_ready_o, 1);
        tick();
        pc_valid_i  = 1'b0;
        instr_gnt_i = 1'b1;
        #1 check("issue_req", instr_req_o, 1);
        check("issue_addr", instr_addr_o, {a[31:2], 2'b00});
        tick();
        instr_gnt_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = d;
        tick();
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        bit          prev_pending;
        bit          prev_flush;
        logic [31:0] prev_addr;
        logic [31:0] epc;
        int          n;

        vecs[0] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{32'h0000_1006, 32'hdead_beef, 32'h0000_1004, 32'h0000_1006};
        vecs[2] = '{32'hffff_fffc, 32'h0000_0000, 32'hffff_fffc, 32'hffff_fffc};
        vecs[3] = '{32'h8000_0001, 32'h1234_5678, 32'h8000_0000, 32'h8000_0001};

        rst_n          = 1'b0;
        pc_i           = '0;
        pc_valid_i     = 1'b1;
        flush_i        = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_ready_i  = 1'b1;

        // Reset
        tick();
        tick();
        #1 check("rst_pc_ready", pc_ready_o, 0);
        check("rst_req", instr_req_o, 0);
        check("rst_addr", instr_addr_o, 0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_instr_pc", instr_pc_o, 0);
        pc_valid_i = 1'b0;
        rst_n      = 1'b1;
        tick();

        // Vector table: single fetches, latency and alignment
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        // Grant withheld: request and address stay put
        pc_valid_i = 1'b1;
        pc_i       = 32'h0000_0040;
        #1;
        tick();
        pc_i = 32'h0000_0080;
        for (int i = 0; i < 4; i++) begin
            #1 check("hold_req", instr_req_o, 1);
            check("hold_addr", instr_addr_o, 32'h40);
            check("hold_pc_ready", pc_ready_o, 0);
            tick();
        end
        pc_valid_i  = 1'b0;
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        #1 check("hold_req_drop", instr_req_o, 0);
        respond(32'h0000_0093);
        #1 check("hold_instr_pc", instr_pc_o, 32'h40);
        check("hold_instr", instr_o, 32'h93);
        tick();

        // Credit limit with decoder stalled
        instr_ready_i = 1'b0;
        issue(32'h0000_0000);
        issue(32'h0000_0004);
        #1 check("credit_full", pc_ready_o, 0);
        respond(32'h1111_0000);
        respond(32'h1111_0004);
        #1 check("credit_buf_full", pc_ready_o, 0);
        check("order0_valid", instr_valid_o, 1);
        check("order0_pc", instr_pc_o, 32'h0);
        check("order0_instr", instr_o, 32'h1111_0000);
        instr_ready_i = 1'b1;
        tick();
        #1 check("order1_pc", instr_pc_o, 32'h4);
        check("order1_instr", instr_o, 32'h1111_0004);
        check("credit_return", pc_ready_o, 1);
        tick();
        #1 check("order_drained", instr_valid_o, 0);

        // Flush with two outstanding
        issue(32'h0000_0200);
        issue(32'h0000_0204);
        flush_i    = 1'b1;
        pc_valid_i = 1'b1;
        pc_i       = 32'h0000_0999;
        #1 check("flush_pc_ready", pc_ready_o, 0);
        tick();
        flush_i    = 1'b0;
        pc_valid_i = 1'b0;
        #1 check("flush_discard_ready", pc_ready_o, 0);
        check("flush_no_req", instr_req_o, 0);
        respond(32'haaaa_0000);
        #1 check("flush_drop0", instr_valid_o, 0);
        respond(32'haaaa_0001);
        #1 check("flush_drop1", instr_valid_o, 0);
        check("flush_ready_back", pc_ready_o, 1);
        issue(32'h0000_0100);
        respond(32'h0010_0093);
        #1 check("flush_new_valid", instr_valid_o, 1);
        check("flush_new_pc", instr_pc_o, 32'h100);
        check("flush_new_instr", instr_o, 32'h0010_0093);
        tick();
        #1 check("flush_new_once", instr_valid_o, 0);

        // Flush while request pending ungranted
        pc_valid_i = 1'b1;
        pc_i       = 32'h0000_0300;
        #1;
        tick();
        pc_valid_i = 1'b0;
        flush_i    = 1'b1;
        #1 check("pend_req_at_flush", instr_req_o, 1);
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check("pend_req_held", instr_req_o, 1);
            check("pend_addr_held", instr_addr_o, 32'h300);
            tick();
        end
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        #1 check("pend_discard_ready", pc_ready_o, 0);
        respond(32'h0000_0bad);
        #1 check("pend_dropped", instr_valid_o, 0);
        check("pend_discard_clear", pc_ready_o, 1);

        // Reset mid-burst
        instr_ready_i = 1'b0;
        issue(32'h0000_0400);
        respond(32'h0000_0011);
        pc_valid_i = 1'b1;
        pc_i       = 32'h0000_0404;
        #1;
        tick();
        pc_valid_i = 1'b0;
        #1 check("mid_req", instr_req_o, 1);
        check("mid_valid", instr_valid_o, 1);
        rst_n = 1'b0;
        #1 check("mid_rst_ready", pc_ready_o, 0);
        tick();
        #1 check("mid_rst_req", instr_req_o, 0);
        check("mid_rst_addr", instr_addr_o, 0);
        check("mid_rst_valid", instr_valid_o, 0);
        check("mid_rst_instr", instr_o, 0);
        check("mid_rst_pc", instr_pc_o, 0);
        rst_n         = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        run_vec(vecs[1]);

        // Randomized traffic against the reference model
        cyc          = 0;
        prev_pending = 1'b0;
        prev_flush   = 1'b0;
        prev_addr    = '0;
        for (int c = 0; c < 4000; c++) begin
            flush_i        = ($urandom_range(0, 39) == 0);
            pc_valid_i     = $urandom_range(0, 1) == 1;
            pc_i           = $urandom;
            instr_gnt_i    = instr_req_o && ($urandom_range(0, 2) != 0);
            instr_rvalid_i = (bus_addr.size() > 0) && (bus_cyc[0] < cyc) &&
                             ($urandom_range(0, 2) != 0);
            instr_rdata_i  = instr_rvalid_i ? mem_data(bus_addr[0]) : $urandom;
            instr_ready_i  = ($urandom_range(0, 3) != 0);
            #1;
            if (flush_i) check("rnd_flush_ready", pc_ready_o, 0);
            if (prev_flush) check("rnd_flush_valid", instr_valid_o, 0);
            if (prev_pending) begin
                check("rnd_req_stable", instr_req_o, 1);
                check("rnd_addr_stable", instr_addr_o, prev_addr);
            end
            if (instr_req_o) check("rnd_addr_align", instr_addr_o[1:0], 0);
            if (pc_valid_i && pc_ready_o) exp_q.push_back(pc_i);
            if (instr_valid_o && instr_ready_i && !flush_i) begin
                check("rnd_expected_any", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    epc = exp_q.pop_front();
                    check("rnd_pc", instr_pc_o, epc);
                    check("rnd_instr", instr_o, mem_data(epc & 32'hffff_fffc));
                end
            end
            if (flush_i) exp_q.delete();
            check("rnd_credit", exp_q.size() <= DEPTH, 1);
            if (instr_req_o && instr_gnt_i) begin
                bus_addr.push_back(instr_addr_o);
                bus_cyc.push_back(cyc);
            end
            if (instr_rvalid_i) begin
                void'(bus_addr.pop_front());
                void'(bus_cyc.pop_front());
            end
            prev_pending = instr_req_o && !instr_gnt_i;
            prev_addr    = instr_addr_o;
            prev_flush   = flush_i;
            tick();
            cyc++;
        end

        // Drain everything still in flight
        flush_i       = 1'b0;
        pc_valid_i    = 1'b0;
        instr_ready_i = 1'b1;
        n             = 0;
        while ((exp_q.size() > 0 || bus_addr.size() > 0 || instr_req_o) && n < 200) begin
            instr_gnt_i    = instr_req_o;
            instr_rvalid_i = (bus_addr.size() > 0) && (bus_cyc[0] < cyc);
            instr_rdata_i  = instr_rvalid_i ? mem_data(bus_addr[0]) : '0;
            #1;
            if (instr_valid_o) begin
                check("drain_expected_any", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    epc = exp_q.pop_front();
                    check("drain_pc", instr_pc_o, epc);
                    check("drain_instr", instr_o, mem_data(epc & 32'hffff_fffc));
                end
            end
            if (instr_req_o && instr_gnt_i) begin
                bus_addr.push_back(instr_addr_o);
                bus_cyc.push_back(cyc);
            end
            if (instr_rvalid_i) begin
                void'(bus_addr.pop_front());
                void'(bus_cyc.pop_front());
            end
            tick();
            cyc++;
            n++;
        end
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        #1;
        if (instr_valid_o) begin
            check("drain_last_any", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                epc = exp_q.pop_front();
                check("drain_last_pc", instr_pc_o, epc);
            end
        end
        check("drain_model_empty", exp_q.size(), 0);
        check("drain_bus_empty", bus_addr.size(), 0);
        tick();
        #1 check("drain_valid_low", instr_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
